program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Instruction sequencer that fetches 32-bit instruction words from a synchronous program ROM and issues them to the ALU/register datapath (alu_register_verilog).
- Each word is {operator[15:0], operand[15:0]}.
- Flow-control opcodes (jump, conditional branch on ALU flags, halt) are consumed internally. Datapath opcodes are driven onto the datapath operator/operand buses for exactly one cycle.
- Sits between the program ROM and alu_register_verilog. Started and monitored by a host through a start/busy/done handshake.

Parameters:
- ADDR_W, 8, program counter / ROM address width.
- DATA_W, 16, width of the operator and operand fields.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- start  in  1  one-cycle request to run from start_addr; honoured only in IDLE.
- abort  in  1  synchronous stop; effective in any non-IDLE state.
- start_addr  in  ADDR_W  first instruction address.
- rom_addr  out  ADDR_W  ROM read address; ROM returns data 1 cycle later.
- rom_data  in  2*DATA_W  {operator, operand} for the address presented the previous cycle.
- operator  out  DATA_W  datapath operator; 16'h0000 (NOP) when not issuing.
- operand  out  DATA_W  datapath operand; 16'h0000 when not issuing.
- alu_flags  in  4  datapath flags {V,N,C,Z}, valid the cycle after an ALU issue.
- busy  out  1  high while in FETCH or EXEC.
- done  out  1  one-cycle pulse when HALT is executed.
- pc  out  ADDR_W  current program counter.
- insn_count  out  16  instructions executed since the last start; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - pc, rom_addr, operator, operand, insn_count, flag_q = 0.
  - busy = 0, done = 0.
- States and transitions:
  - IDLE → FETCH on start: pc <= start_addr, insn_count <= 0.
  - FETCH: rom_addr = pc. If the previous EXEC issued an ALU op, flag_q <= alu_flags. → EXEC.
  - EXEC: decode rom_data[31:24]. Then go to FETCH, or to IDLE on HALT.
- Throughput: one instruction per 2 cycles. Latency from start to first datapath issue is 2 cycles (FETCH, EXEC).
- Opcodes (operator[15:8]):
  - 0x10–0x14 (ALU), 0x21 (load), 0x22 (read): drive operator/operand for the EXEC cycle only; pc <= pc+1. ALU ops set the alu_pending flag for the next FETCH.
  - 0x00 NOP, and any undefined opcode: no issue; pc <= pc+1.
  - 0x30 JMP: pc <= operand[ADDR_W-1:0].
  - 0x31 JZ: if flag_q[0], pc <= target; else pc+1.
  - 0x32 JNZ: if !flag_q[0], pc <= target; else pc+1.
  - 0x33 JC: if flag_q[1], pc <= target; else pc+1.
  - 0x3F HALT: pc holds; done = 1 for that cycle; → IDLE.
- insn_count increments on every EXEC, including flow control and HALT, and saturates at 16'hFFFF.
- pc increment wraps modulo 2^ADDR_W (0xFF+1 → 0x00 at default width).
- flag_q holds its value across non-ALU instructions. A branch uses the flags of the most recent ALU op. flag_q is 0 if no ALU op has run since start.
- abort in FETCH or EXEC:
  - → IDLE next cycle.
  - operator/operand forced to 0 that cycle; no issue, even in EXEC.
  - done is not pulsed; pc and insn_count freeze.
- abort has priority over HALT and over issue in the same cycle.
- start while busy is ignored. start and abort together in IDLE: start wins (abort has no effect in IDLE).
- reset mid-run returns immediately to the reset values. Any in-flight datapath op is dropped.

Decomposition:
- Shared package seq_pkg holds:
  - opcode localparams OP_NOP, OP_ADD..OP_XOR (0x10–0x14), OP_LOAD 0x21, OP_READ 0x22, OP_JMP 0x30, OP_JZ 0x31, OP_JNZ 0x32, OP_JC 0x33, OP_HALT 0x3F;
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3;
  - state encoding IDLE/FETCH/EXEC.
- One natural sub-module: seq_decode, a combinational opcode classifier (is_issue, is_alu, is_branch, taken, is_halt). It is shared with the bench's reference model.
- Top level includes program_sequencer wired to alu_register_verilog and a ROM model.

Test Plan:
- Straight line: ROM[0]=LOAD R1,4; [1]=LOAD R2,5; [2]=ADD R3←R2+R1; [3]=READ R3; [4]=HALT; start_addr=0 → four single-cycle issues on cycles 2,4,6,8 after start; reg_read_data=9; done pulse on cycle 10; insn_count=5; pc=4.
- Branch taken: XOR R3←R1^R1 (Z=1), then JZ 0x10; ROM[0x10]=HALT → next fetch address 0x10; done asserted; the skipped instruction is never issued.
- Branch not taken: ADD 4+5 (Z=0), then JZ 0x10 → pc advances by 1. JNZ in the same position instead jumps to 0x10.
- Wrap and undefined: start_addr=0xFE; ROM[0xFE]=0x77xx (undefined); [0xFF]=NOP; [0x00]=HALT → no datapath issue for the undefined opcode or the NOP; pc wraps to 0x00; done asserted; insn_count=3.
- Abort: assert abort in the EXEC of an ADD → operator stays 0 that cycle; state IDLE; busy=0; no done. A new start runs from start_addr with insn_count reset to 0.
- Reset mid-run: drive reset=0 during FETCH → all outputs 0 immediately (async). After release, start is accepted and start is ignored while busy=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode, flag-index and state definitions for the program sequencer.
// Instruction words are {operator[15:0], operand[15:0]}; the opcode is operator[15:8].
package seq_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_SUB  = 8'h11;
    localparam logic [7:0] OP_AND  = 8'h12;
    localparam logic [7:0] OP_OR   = 8'h13;
    localparam logic [7:0] OP_XOR  = 8'h14;
    localparam logic [7:0] OP_LOAD = 8'h21;
    localparam logic [7:0] OP_READ = 8'h22;
    localparam logic [7:0] OP_JMP  = 8'h30;
    localparam logic [7:0] OP_JZ   = 8'h31;
    localparam logic [7:0] OP_JNZ  = 8'h32;
    localparam logic [7:0] OP_JC   = 8'h33;
    localparam logic [7:0] OP_HALT = 8'h3F;

    // Bit positions inside the {V,N,C,Z} datapath flag nibble.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    function automatic logic is_alu_op(input logic [7:0] opcode);
        return (opcode >= OP_ADD) && (opcode <= OP_XOR);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier: which opcodes reach the datapath, which
// are ALU ops, which redirect the program counter and whether they do so.
module seq_decode
    import seq_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [3:0] flags,
    output logic       is_issue,
    output logic       is_alu,
    output logic       is_branch,
    output logic       taken,
    output logic       is_halt
);

    logic unused_flags;
    assign unused_flags = ^{flags[FLAG_V], flags[FLAG_N]};

    always_comb begin
        is_issue  = 1'b0;
        is_alu    = 1'b0;
        is_branch = 1'b0;
        taken     = 1'b0;
        is_halt   = 1'b0;
        if (is_alu_op(opcode)) begin
            is_issue = 1'b1;
            is_alu   = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_READ: is_issue = 1'b1;
                OP_JMP: begin
                    is_branch = 1'b1;
                    taken     = 1'b1;
                end
                OP_JZ: begin
                    is_branch = 1'b1;
                    taken     = flags[FLAG_Z];
                end
                OP_JNZ: begin
                    is_branch = 1'b1;
                    taken     = ~flags[FLAG_Z];
                end
                OP_JC: begin
                    is_branch = 1'b1;
                    taken     = flags[FLAG_C];
                end
                OP_HALT: is_halt = 1'b1;
                // NOP and undefined opcodes fall through as a plain pc+1.
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Two-cycle (FETCH, EXEC) instruction sequencer between a synchronous program
// ROM and the ALU/register datapath, with a host start/busy/done handshake.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     start_addr,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [2*DATA_W-1:0]   rom_data,
    output logic [DATA_W-1:0]     operator,
    output logic [DATA_W-1:0]     operand,
    input  logic [3:0]            alu_flags,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     pc,
    output logic [15:0]           insn_count,
    output seq_state_e            state_dbg
);

    // Host handshake: start is a request sampled only in IDLE; busy is high
    // from the cycle after an accepted start until the cycle after HALT/abort;
    // done pulses for exactly the EXEC cycle of a HALT that was not aborted.

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       insn_count_q, insn_count_d;
    logic [3:0]        flag_q, flag_d;
    logic              alu_pending_q, alu_pending_d;

    logic [7:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic              dec_issue, dec_alu, dec_branch, dec_taken, dec_halt;
    logic              issue_c, done_c;

    assign opcode = rom_data[2*DATA_W-1 -: 8];
    assign target = rom_data[ADDR_W-1:0];

    seq_decode u_decode (
        .opcode   (opcode),
        .flags    (flag_q),
        .is_issue (dec_issue),
        .is_alu   (dec_alu),
        .is_branch(dec_branch),
        .taken    (dec_taken),
        .is_halt  (dec_halt)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        insn_count_d  = insn_count_q;
        flag_d        = flag_q;
        alu_pending_d = alu_pending_q;
        issue_c       = 1'b0;
        done_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FETCH;
                    pc_d          = start_addr;
                    insn_count_d  = 16'h0000;
                    flag_d        = 4'h0;
                    alu_pending_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Flags of an ALU op issued last EXEC are valid during this cycle.
                    if (alu_pending_q) begin
                        flag_d = alu_flags;
                    end
                    alu_pending_d = 1'b0;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (insn_count_q != 16'hFFFF) begin
                        insn_count_d = insn_count_q + 16'd1;
                    end
                    if (dec_halt) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        state_d       = ST_FETCH;
                        issue_c       = dec_issue;
                        alu_pending_d = dec_alu;
                        if (dec_branch && dec_taken) begin
                            pc_d = target;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            insn_count_q  <= 16'h0000;
            flag_q        <= 4'h0;
            alu_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            insn_count_q  <= insn_count_d;
            flag_q        <= flag_d;
            alu_pending_q <= alu_pending_d;
        end
    end

    // The ROM answers one cycle after the address, so the EXEC word is decoded
    // and issued combinationally; abort gates the issue in that same cycle.
    assign operator   = issue_c ? rom_data[2*DATA_W-1:DATA_W] : '0;
    assign operand    = issue_c ? rom_data[DATA_W-1:0] : '0;
    assign rom_addr   = pc_q;
    assign pc         = pc_q;
    assign insn_count = insn_count_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_c;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench: program_sequencer driving a ROM model and a small
// register-file/ALU model; each task runs one scenario and checks inline.
module tb_program_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  start_addr;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [15:0] operator;
    logic [15:0] operand;
    logic [3:0]  alu_flags;
    logic        busy;
    logic        done;
    logic [7:0]  pc;
    logic [15:0] insn_count;
    seq_state_e  state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .start_addr(start_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .operator  (operator),
        .operand   (operand),
        .alu_flags (alu_flags),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .insn_count(insn_count),
        .state_dbg (state_dbg)
    );

    // Synchronous program ROM.
    logic [31:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Datapath: operator[3:0] = destination / read register,
    // operand[7:4] = source A, operand[3:0] = source B.
    logic [15:0] regs [16];
    logic [15:0] read_data;
    logic [3:0]  flags_q;
    logic [19:0] alu_out;

    function automatic logic [19:0] alu_eval(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                r = {1'b0, a} + {1'b0, b};
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            OP_SUB: begin
                r = {1'b0, a} - {1'b0, b};
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            OP_AND: r = {1'b0, a & b};
            OP_OR:  r = {1'b0, a | b};
            OP_XOR: r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return {v, r[15], r[16], (r[15:0] == 16'h0000), r[15:0]};
    endfunction

    assign alu_out   = alu_eval(operator[15:8], regs[operand[7:4]], regs[operand[3:0]]);
    assign alu_flags = flags_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            read_data <= 16'h0000;
            flags_q   <= 4'h0;
        end else begin
            case (operator[15:8])
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    regs[operator[3:0]] <= alu_out[15:0];
                    flags_q             <= alu_out[19:16];
                end
                OP_LOAD: regs[operator[3:0]] <= operand;
                OP_READ: read_data <= regs[operator[3:0]];
                default: ;
            endcase
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom;
        foreach (rom[i]) rom[i] = 32'h0;
    endtask

    // Pulses start for one cycle; returns in cycle 1 (the first FETCH).
    task automatic kick(input logic [7:0] addr);
        start_addr = addr;
        start      = 1'b1;
        step;
        start      = 1'b0;
    endtask

    task automatic load_straight_line;
        clear_rom;
        rom[0] = 32'h2101_0004;
        rom[1] = 32'h2102_0005;
        rom[2] = 32'h1003_0021;
        rom[3] = 32'h2203_0000;
        rom[4] = 32'h3F00_0000;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({operator, operand} !== 32'h0 || pc !== 8'h00 || rom_addr !== 8'h00 || insn_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got op=%h opd=%h pc=%h addr=%h cnt=%h, expected all zero", operator, operand, pc, rom_addr, insn_count);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b state=%0d, expected 0 0 0", busy, done, state_dbg);
        end
        step;
        step;
        reset = 1'b1;
        step;
        checks++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got state=%0d busy=%b pc=%h, expected IDLE 0 00", state_dbg, busy, pc);
        end
    endtask

    task automatic test_straight_line;
        logic [31:0] exp_bus;
        load_straight_line;
        kick(8'h00);
        for (int k = 1; k <= 11; k++) begin
            case (k)
                2:       exp_bus = 32'h2101_0004;
                4:       exp_bus = 32'h2102_0005;
                6:       exp_bus = 32'h1003_0021;
                8:       exp_bus = 32'h2203_0000;
                default: exp_bus = 32'h0;
            endcase
            checks++;
            if ({operator, operand} !== exp_bus) begin
                errors++;
                $display("FAIL straight_issue cycle %0d: got %h, expected %h", k, {operator, operand}, exp_bus);
            end
            checks++;
            if (done !== (k == 10) || busy !== (k <= 10)) begin
                errors++;
                $display("FAIL straight_handshake cycle %0d: got done=%b busy=%b, expected %b %b", k, done, busy, (k == 10), (k <= 10));
            end
            step;
        end
        checks++;
        if (pc !== 8'h04 || insn_count !== 16'd5 || read_data !== 16'd9 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL straight_final: got pc=%h cnt=%0d rd=%0d state=%0d, expected 04 5 9 IDLE", pc, insn_count, read_data, state_dbg);
        end
    endtask

    task automatic test_branch_taken;
        logic [31:0] exp_bus;
        clear_rom;
        rom[0]     = 32'h2101_0004;
        rom[1]     = 32'h1403_0011;
        rom[2]     = 32'h3100_0010;
        rom[3]     = 32'h2105_0007;
        rom[8'h10] = 32'h3F00_0000;
        kick(8'h00);
        for (int k = 1; k <= 9; k++) begin
            case (k)
                2:       exp_bus = 32'h2101_0004;
                4:       exp_bus = 32'h1403_0011;
                default: exp_bus = 32'h0;
            endcase
            checks++;
            if ({operator, operand} !== exp_bus || done !== (k == 8)) begin
                errors++;
                $display("FAIL jz_taken cycle %0d: got bus=%h done=%b, expected %h %b", k, {operator, operand}, done, exp_bus, (k == 8));
            end
            if (k == 7) begin
                checks++;
                if (rom_addr !== 8'h10) begin
                    errors++;
                    $display("FAIL jz_taken_fetch: got addr=%h, expected 10", rom_addr);
                end
            end
            step;
        end
        checks++;
        if (pc !== 8'h10 || insn_count !== 16'd4) begin
            errors++;
            $display("FAIL jz_taken_final: got pc=%h cnt=%0d, expected 10 4", pc, insn_count);
        end
    endtask

    task automatic test_branch_cond(input logic [7:0] op, input logic [7:0] exp_pc);
        load_straight_line;
        rom[3]     = {op, 24'h00_0010};
        rom[8'h10] = 32'h3F00_0000;
        kick(8'h00);
        for (int k = 1; k <= 11; k++) begin
            checks++;
            if (done !== (k == 10)) begin
                errors++;
                $display("FAIL branch_%h_done cycle %0d: got %b, expected %b", op, k, done, (k == 10));
            end
            if (k == 9) begin
                checks++;
                if (rom_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL branch_%h_fetch: got addr=%h, expected %h", op, rom_addr, exp_pc);
                end
            end
            step;
        end
        checks++;
        if (pc !== exp_pc || insn_count !== 16'd5) begin
            errors++;
            $display("FAIL branch_%h_final: got pc=%h cnt=%0d, expected %h 5", op, pc, insn_count, exp_pc);
        end
    endtask

    task automatic test_jc_flag_hold;
        clear_rom;
        rom[0]     = 32'h2101_FFFF;
        rom[1]     = 32'h2102_0001;
        rom[2]     = 32'h1003_0012;
        rom[3]     = 32'h2104_0000;
        rom[4]     = 32'h3300_0020;
        rom[5]     = 32'h3F00_0000;
        rom[8'h20] = 32'h3F00_0000;
        kick(8'h00);
        for (int k = 1; k <= 13; k++) begin
            checks++;
            if (done !== (k == 12)) begin
                errors++;
                $display("FAIL jc_done cycle %0d: got %b, expected %b", k, done, (k == 12));
            end
            step;
        end
        checks++;
        if (pc !== 8'h20 || insn_count !== 16'd6) begin
            errors++;
            $display("FAIL jc_final: got pc=%h cnt=%0d, expected 20 6", pc, insn_count);
        end
    endtask

    task automatic test_flags_cleared_on_start;
        clear_rom;
        rom[0]     = 32'h3100_0010;
        rom[1]     = 32'h3F00_0000;
        rom[8'h10] = 32'h3F00_0000;
        kick(8'h00);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (done !== (k == 4)) begin
                errors++;
                $display("FAIL fresh_flags_done cycle %0d: got %b, expected %b", k, done, (k == 4));
            end
            step;
        end
        checks++;
        if (pc !== 8'h01 || insn_count !== 16'd2) begin
            errors++;
            $display("FAIL fresh_flags_final: got pc=%h cnt=%0d, expected 01 2", pc, insn_count);
        end
    endtask

    task automatic test_wrap_undefined;
        clear_rom;
        rom[8'hFE] = 32'h7712_3456;
        rom[8'hFF] = 32'h0000_0000;
        rom[8'h00] = 32'h3F00_0000;
        kick(8'hFE);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if ({operator, operand} !== 32'h0 || done !== (k == 6)) begin
                errors++;
                $display("FAIL wrap cycle %0d: got bus=%h done=%b, expected 0 %b", k, {operator, operand}, done, (k == 6));
            end
            if (k == 5) begin
                checks++;
                if (rom_addr !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_fetch: got addr=%h, expected 00", rom_addr);
                end
            end
            step;
        end
        checks++;
        if (pc !== 8'h00 || insn_count !== 16'd3) begin
            errors++;
            $display("FAIL wrap_final: got pc=%h cnt=%0d, expected 00 3", pc, insn_count);
        end
    endtask

    task automatic test_abort;
        clear_rom;
        rom[0] = 32'h2101_0004;
        rom[1] = 32'h2102_0005;
        rom[2] = 32'h1003_0021;
        rom[3] = 32'h3F00_0000;
        kick(8'h00);
        for (int k = 1; k < 6; k++) step;
        checks++;
        if ({operator, operand} !== 32'h1003_0021) begin
            errors++;
            $display("FAIL abort_pre_issue: got %h, expected 10030021", {operator, operand});
        end
        abort = 1'b1;
        #1;
        checks++;
        if ({operator, operand} !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_gate: got bus=%h done=%b, expected 0 0", {operator, operand}, done);
        end
        step;
        abort = 1'b0;
        checks++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || done !== 1'b0 || pc !== 8'h02 || insn_count !== 16'd2) begin
            errors++;
            $display("FAIL abort_state: got state=%0d busy=%b done=%b pc=%h cnt=%0d, expected IDLE 0 0 02 2", state_dbg, busy, done, pc, insn_count);
        end
        checks++;
        if (regs[3] !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_write: got R3=%h, expected 0000", regs[3]);
        end
        step;
        // start and abort together in IDLE: start is taken.
        abort = 1'b1;
        kick(8'h00);
        abort = 1'b0;
        checks++;
        if (state_dbg !== ST_FETCH || busy !== 1'b1 || insn_count !== 16'd0) begin
            errors++;
            $display("FAIL restart: got state=%0d busy=%b cnt=%0d, expected FETCH 1 0", state_dbg, busy, insn_count);
        end
        for (int k = 1; k <= 8; k++) begin
            step;
            checks++;
            if (done !== (k == 7)) begin
                errors++;
                $display("FAIL restart_done cycle %0d: got %b, expected %b", k + 1, done, (k == 7));
            end
        end
        checks++;
        if (pc !== 8'h03 || insn_count !== 16'd4) begin
            errors++;
            $display("FAIL restart_final: got pc=%h cnt=%0d, expected 03 4", pc, insn_count);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] exp_bus;
        load_straight_line;
        kick(8'h00);
        step;
        step;
        checks++;
        if (state_dbg !== ST_FETCH || insn_count !== 16'd1) begin
            errors++;
            $display("FAIL midrun_pre: got state=%0d cnt=%0d, expected FETCH 1", state_dbg, insn_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({operator, operand} !== 32'h0 || pc !== 8'h00 || rom_addr !== 8'h00 || insn_count !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL midrun_reset: got bus=%h pc=%h addr=%h cnt=%h busy=%b done=%b state=%0d, expected all zero/IDLE", {operator, operand}, pc, rom_addr, insn_count, busy, done, state_dbg);
        end
        #3;
        reset = 1'b1;
        step;
        kick(8'h00);
        for (int k = 1; k <= 11; k++) begin
            start      = (k == 3) || (k == 5);
            start_addr = start ? 8'h40 : 8'h00;
            case (k)
                2:       exp_bus = 32'h2101_0004;
                4:       exp_bus = 32'h2102_0005;
                6:       exp_bus = 32'h1003_0021;
                8:       exp_bus = 32'h2203_0000;
                default: exp_bus = 32'h0;
            endcase
            checks++;
            if ({operator, operand} !== exp_bus || busy !== (k <= 10) || done !== (k == 10)) begin
                errors++;
                $display("FAIL busy_start cycle %0d: got bus=%h busy=%b done=%b, expected %h %b %b", k, {operator, operand}, busy, done, exp_bus, (k <= 10), (k == 10));
            end
            step;
        end
        start = 1'b0;
        checks++;
        if (pc !== 8'h04 || insn_count !== 16'd5 || read_data !== 16'd9) begin
            errors++;
            $display("FAIL busy_start_final: got pc=%h cnt=%0d rd=%0d, expected 04 5 9", pc, insn_count, read_data);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = 8'h00;
        clear_rom;
        test_reset;
        test_straight_line;
        test_branch_taken;
        test_branch_cond(OP_JZ, 8'h04);
        test_branch_cond(OP_JNZ, 8'h10);
        test_jc_flag_hold;
        test_flags_cleared_on_start;
        test_wrap_undefined;
        test_abort;
        test_reset_mid_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
